// File: rtl/axis_fifo_reader_if.sv
// AXI-Stream bundle: tdata/tvalid/tlast from master, tready from slave.
// Modports: master drives data side, slave drives tready.
interface axis_fifo_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_fifo_reader.sv
// Drains a sync FIFO read port (1-cycle latency) into an AXIS master.
// Ports: clk, reset, fifo_rd_en/fifo_empty/fifo_out, m_axis, idle.
module axis_fifo_reader #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_rd_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_out,
  axis_fifo_reader_if.master m_axis,
  output logic              idle
);
  localparam int CNT_W = $clog2(PKT_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] mem [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic              rd_pending;
  logic [CNT_W-1:0]  beat_cnt;
  logic              push;
  logic              pop;
  logic [2:0]        occ;

  assign push = rd_pending;
  assign pop  = m_axis.tvalid & m_axis.tready;

  // Occupancy after this edge, counting the read in flight.
  assign occ = {1'b0, count}
             + {2'b0, rd_pending}
             - {2'b0, pop};

  assign fifo_rd_en = !reset & !fifo_empty
                    & (occ < 3'd2);

  assign m_axis.tvalid = (count != 2'd0);
  assign m_axis.tdata  = mem[head];
  assign m_axis.tlast  = m_axis.tvalid
                       & (beat_cnt == LAST);

  assign idle = (count == 2'd0) & !rd_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      rd_pending <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (push) begin
        mem[tail] <= fifo_out;
        tail      <= ~tail;
      end
      if (pop) begin
        head     <= ~head;
        beat_cnt <= (beat_cnt == LAST)
                  ? '0 : beat_cnt + 1'b1;
      end
      unique case (1'b1)
        push & !pop: count <= count + 2'd1;
        pop & !push: count <= count - 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_fifo_reader.sv
// Bench for axis_fifo_reader: queue FIFO model, stream scoreboard.
// Ports: drives clk/reset/fifo side, consumes m_axis through interface.
module tb_axis_fifo_reader;
  localparam int DW = 32;
  localparam int PL = 4;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          fifo_clr   = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_out   = '0;
  logic          idle;

  axis_fifo_reader_if #(.DATA_W(DW)) axs ();

  axis_fifo_reader #(
    .DATA_W (DW),
    .PKT_LEN(PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty),
    .fifo_out  (fifo_out),
    .m_axis    (axs.master),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  logic [DW-1:0] fq[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] expq[$];

  // Upstream FIFO: writes staged in wq land at the edge,
  // reads return data one cycle later, junk otherwise.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      wq.delete();
      expq.delete();
    end else begin
      if (fifo_rd_en && !fifo_empty)
        fifo_out <= fq.pop_front();
      else
        fifo_out <= $urandom;
      while (wq.size() > 0)
        fq.push_back(wq.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic put(input logic [DW-1:0] w);
    wq.push_back(w);
    expq.push_back(w);
  endtask

  int            beat_idx = 0;
  int            n_last   = 0;
  logic          pv       = 1'b0;
  logic [DW-1:0] pd       = '0;
  logic          pl       = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      beat_idx = 0;
      pv       = 1'b0;
    end else begin
      chk("rd_when_empty",
          fifo_rd_en & fifo_empty, 0);
      if (pv) begin
        chk("hold_valid", axs.tvalid, 1);
        chk("hold_data", axs.tdata, pd);
        chk("hold_last", axs.tlast, pl);
      end
      if (axs.tvalid && axs.tready) begin
        if (expq.size() == 0)
          chk("extra_beat", 1, 0);
        else
          chk("beat_data", axs.tdata,
              expq.pop_front());
        chk("beat_last", axs.tlast,
            (beat_idx % PL) == PL - 1);
        if (axs.tlast) n_last++;
        beat_idx++;
      end
      pv = axs.tvalid & !axs.tready;
      pd = axs.tdata;
      pl = axs.tlast;
    end
  end

  always @(negedge clk)
    if (!reset)
      assert (dut.count <= 2'd2)
      else $error("FAIL count_ovf count=%0d",
                  dut.count);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int mode,
                       input int max);
    int n;
    n = 0;
    while (!(idle && fifo_empty &&
             wq.size() == 0) && n < max) begin
      case (mode)
        0: axs.tready = 1'b1;
        1: axs.tready = ~axs.tready;
        default: axs.tready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask

  task automatic do_reset(input logic clr);
    reset    = 1'b1;
    fifo_clr = clr;
    tick();
    reset    = 1'b0;
    fifo_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int ln;
    int bi;
    logic found;
    axs.tready = 1'b0;
    for (int i = 0; i < 4; i++)
      put(32'hA0 + 32'(i));

    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", axs.tvalid, 0);
    chk("rst_last", axs.tlast, 0);
    chk("rst_data", axs.tdata, 0);
    chk("rst_idle", idle, 1);

    @(posedge clk);
    #1;
    reset      = 1'b0;
    axs.tready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("post_rst_valid", axs.tvalid, 0);
        chk("post_rst_data", axs.tdata, 0);
        chk("post_rst_idle", idle, 1);
      end
      chk("t2_rd_en", fifo_rd_en, c <= 3);
      chk("t2_valid", axs.tvalid,
          c >= 2 && c <= 5);
      if (c >= 2 && c <= 5)
        chk("t2_data", axs.tdata,
            64'(32'hA0 + 32'(c - 2)));
      if (c == 6) chk("t2_idle", idle, 1);
    end
    #1;

    for (int i = 0; i < 8; i++) put($urandom);
    drain(1, 100);
    chk("t3_all_out", expq.size(), 0);

    do_reset(1'b0);
    ln = n_last;
    for (int i = 0; i < 10; i++) put($urandom);
    drain(0, 100);
    chk("t4_nlast", n_last - ln, 2);
    chk("t4_beats", beat_idx, 10);
    chk("t4_beat_cnt", dut.beat_cnt, 2);

    ln = n_last;
    put($urandom);
    put($urandom);
    drain(0, 50);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_gap_valid", axs.tvalid, 0);
    end
    for (int i = 0; i < 3; i++) put($urandom);
    drain(0, 50);
    chk("t5_nlast", n_last - ln, 1);
    chk("t5_beat_cnt", dut.beat_cnt,
        beat_idx % PL);

    axs.tready = 1'b0;
    for (int i = 0; i < 4; i++) put($urandom);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (axs.tvalid && dut.rd_pending)
        found = 1'b1;
    end
    chk("t6_reach", found, 1);
    reset    = 1'b1;
    fifo_clr = 1'b1;
    tick();
    reset    = 1'b0;
    fifo_clr = 1'b0;
    chk("t6_valid", axs.tvalid, 0);
    chk("t6_beat_cnt", dut.beat_cnt, 0);
    chk("t6_idle", idle, 1);
    ln = n_last;
    for (int i = 0; i < 6; i++) put($urandom);
    drain(2, 200);
    chk("t6_nlast", n_last - ln, 1);
    chk("t6_all_out", expq.size(), 0);

    for (int i = 0; i < 300; i++) begin
      axs.tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        put($urandom);
      tick();
    end
    drain(2, 1000);
    chk("t7_all_out", expq.size(), 0);
    bi = beat_idx;
    chk("t7_beat_cnt", dut.beat_cnt, bi % PL);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end
endmodule
